gmsk_bit_sync: RTL and testbench
================================

Name: gmsk_bit_sync

Overview:
- Downstream neighbour of the demodulator low-pass stage: consumes its filtered, sample-rate soft output.
- Produces hard bit decisions through a hysteresis slicer and a zero-crossing symbol-timing loop.
- Hunts for a sync word, then frames a fixed-length payload for the packet layer.
- Runs on the system clock with its own sample-enable divider, matching the upstream sample timing.

Parameters:
- DATA_WIDTH, 7: width of signed soft input.
- SYS_CLK_FREQ, 6_400_000: system clock in Hz.
- SAMPLE_RATE, 800: soft-sample rate in Hz. SAMPLE_DIV = SYS_CLK_FREQ/SAMPLE_RATE.
- SAMPLES_PER_BIT, 8: oversampling ratio. Even, ≥4.
- HYST, 2: slicer hysteresis threshold, positive integer < 2^(DATA_WIDTH-1).
- SYNC_LEN, 8: sync word length in bits, ≤32.
- SYNC_WORD, 8'hB4: sync pattern, MSB received first.
- FRAME_BITS, 32: payload bits per frame, ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  enable; low forces idle.
- sample_in  in  DATA_WIDTH signed  filtered soft sample.
- bit_out  out  1  decided bit.
- bit_valid  out  1  one-clk pulse per decided bit.
- payload_valid  out  1  one-clk pulse, equal to bit_valid while locked.
- sync_found  out  1  one-clk pulse on sync match.
- frame_done  out  1  one-clk pulse with last payload bit.
- locked  out  1  high in PAYLOAD state.

Behaviour:
- Reset (rst=1 at clk edge) clears the following, and all outputs read 0 the following cycle:
  - divider, sample_en, slicer state, phase counter, sync shift register, bit counter, FSM (HUNT).
- Divider:
  - Counts 0..SAMPLE_DIV-1 while start=1.
  - sample_en pulses for one clk in the cycle after the counter wraps.
  - start=0 holds the counter and sample_en at 0.
- Slicer, evaluated only on sample_en:
  - sign<=1 if sample_in > +HYST; sign<=0 if sample_in < -HYST; otherwise hold.
  - Comparison is signed at DATA_WIDTH+1 bits; no overflow.
  - "transition" = new sign differs from old sign.
- Timing loop:
  - phase counter 0..SAMPLES_PER_BIT-1; wraps to 0; advances by 1 on each sample_en.
  - On a transition with old phase p, only one correction step per transition (±1):
    - p==0 or p==SPB/2: normal advance.
    - 1≤p<SPB/2 (late): phase holds at p.
    - p>SPB/2: phase<=(p+2) mod SPB.
- Decision:
  - On sample_en with old phase==SPB/2: bit_out<=new sign; bit_valid=1 next clk for one clk.
  - bit_out holds between decisions.
- FSM:
  - HUNT:
    - Each decided bit shifts into the SYNC_LEN-bit register (new bit LSB).
    - If the updated register == SYNC_WORD, pulse sync_found with that bit's bit_valid, clear the bit counter, and go to PAYLOAD.
    - A matching bit is not counted as payload.
  - PAYLOAD:
    - locked=1; each bit_valid also asserts payload_valid and increments the bit counter.
    - On the FRAME_BITS-th bit, frame_done pulses with that bit_valid.
    - Next state is HUNT; the sync register is cleared so no overlapped re-match occurs.
- start=0 at any time, next clk:
  - FSM->HUNT, locked=0; sync register, bit counter and phase cleared.
  - No pulses are issued; slicer sign and bit_out are held.
- rst has priority over start. Reset mid-frame aborts the frame with no frame_done.

Optional Feature:
- GMSK_SYNC_TOL_EN defined: HUNT accepts a match when the Hamming distance between register and SYNC_WORD is ≤1, and sync_found pulses on the first such bit.
- Undefined: exact match only. The distance logic is not synthesised.

Test Plan (sim override SYS_CLK_FREQ=8000 → SAMPLE_DIV=10):
1. Reset:
   - Stimulus: rst high 3 clks, sample_in=+20, start=1.
   - Response: all outputs 0 during reset and the first post-reset clk; first sample_en 10 clks after release.
2. Constant level:
   - Stimulus: sample_in=+20 for 32 samples.
   - Response: bit_valid every 80 clks; bit_out=1; no sync_found.
3. Hysteresis:
   - Stimulus: +20 then ±1, ±2 alternating for 16 samples.
   - Response: sign stays 1, bit_out=1. Then -3 flips sign and the next decision gives 0.
4. Timing:
   - Stimulus: alternating 8-sample bits (±20) with first transition at phase 3.
   - Response: phase held once per transition; transitions land at phase 0 after 3 transitions; decisions alternate 1/0 thereafter.
5. Frame:
   - Stimulus: bits 0xB4 then 0xDEADBEEF, MSB first.
   - Response:
     - sync_found once, with the 8th sync bit.
     - 32 payload_valid pulses with bits 0xDEADBEEF.
     - frame_done with the 32nd; locked falls next clk.
     - Repeat 0xB4 re-syncs.
6. Abort and tolerance:
   - start=0 after 10 payload bits → locked=0 next clk; no further pulses; restart needs a fresh sync.
   - Send 0xB5:
     - With GMSK_SYNC_TOL_EN: sync_found.
     - Without GMSK_SYNC_TOL_EN: none.

Source files
------------

// File: rtl/gmsk_bit_sync_if.sv
// Soft-sample input and bit/frame event outputs of the GMSK bit synchroniser.
// master = upstream/packet side, slave = gmsk_bit_sync.
interface gmsk_bit_sync_if #(
    parameter int DATA_WIDTH = 7
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         bit_out;
    logic                         bit_valid;
    logic                         payload_valid;
    logic                         sync_found;
    logic                         frame_done;
    logic                         locked;

    modport master (
        output start, sample_in,
        input  bit_out, bit_valid, payload_valid, sync_found, frame_done, locked
    );

    modport slave (
        input  start, sample_in,
        output bit_out, bit_valid, payload_valid, sync_found, frame_done, locked
    );
endinterface

// File: rtl/gmsk_bit_sync.sv
// Hysteresis slicer, zero-crossing timing loop, sync-word hunt and payload framer.
// Define GMSK_SYNC_TOL_EN to accept a sync word with up to one bit error.
module gmsk_bit_sync #(
    parameter int                DATA_WIDTH      = 7,
    parameter int                SYS_CLK_FREQ    = 6_400_000,
    parameter int                SAMPLE_RATE     = 800,
    parameter int                SAMPLES_PER_BIT = 8,
    parameter int                HYST            = 2,
    parameter int                SYNC_LEN        = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD     = 8'hB4,
    parameter int                FRAME_BITS      = 32
) (
    input  logic          clk,
    input  logic          rst,
    gmsk_bit_sync_if.slave bus
);
    localparam int SAMPLE_DIV = SYS_CLK_FREQ / SAMPLE_RATE;
    localparam int DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PH_W       = $clog2(SAMPLES_PER_BIT);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0]          DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]           HALF     = PH_W'(SAMPLES_PER_BIT / 2);
    localparam logic [PH_W:0]             SPB_W    = (PH_W + 1)'(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic signed [DATA_WIDTH:0] HYST_P  = (DATA_WIDTH + 1)'(HYST);
    localparam logic signed [DATA_WIDTH:0] HYST_N  = -HYST_P;

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div_cnt;
    logic                   sample_en;
    logic                   sign, new_sign, transition;
    logic [PH_W-1:0]        phase, phase_nxt;
    logic [PH_W:0]          ph_p1, ph_p2;
    logic [SYNC_LEN-1:0]    sync_sr, sr_upd;
    logic [SYNC_LEN:0]      sr_cat;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   match;
    logic signed [DATA_WIDTH:0] s_ext;

    // One extra bit of headroom so +/-HYST never overflows against the sample.
    assign s_ext = {bus.sample_in[DATA_WIDTH-1], bus.sample_in};

    always_comb begin
        new_sign = sign;
        if (s_ext > HYST_P)      new_sign = 1'b1;
        else if (s_ext < HYST_N) new_sign = 1'b0;
    end

    assign transition = (new_sign != sign);

    // A crossing before mid-bit means we sample late: hold one step.
    // A crossing after mid-bit means early: skip one step.
    always_comb begin
        ph_p1 = (PH_W + 1)'(phase) + (PH_W + 1)'(1);
        ph_p2 = (PH_W + 1)'(phase) + (PH_W + 1)'(2);
        if (ph_p1 >= SPB_W) ph_p1 = ph_p1 - SPB_W;
        if (ph_p2 >= SPB_W) ph_p2 = ph_p2 - SPB_W;
        phase_nxt = ph_p1[PH_W-1:0];
        if (transition && phase != '0 && phase < HALF) phase_nxt = phase;
        else if (transition && phase > HALF)          phase_nxt = ph_p2[PH_W-1:0];
    end

    always_comb begin
        sr_cat = {sync_sr, new_sign};
        sr_upd = sr_cat[SYNC_LEN-1:0];
    end

`ifdef GMSK_SYNC_TOL_EN
    assign match = ($countones(sr_upd ^ SYNC_WORD) <= 1);
`else
    assign match = (sr_upd == SYNC_WORD);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt           <= '0;
            sample_en         <= 1'b0;
            sign              <= 1'b0;
            phase             <= '0;
            sync_sr           <= '0;
            bit_cnt           <= '0;
            state             <= HUNT;
            bus.bit_out       <= 1'b0;
            bus.bit_valid     <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.sync_found    <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.locked        <= 1'b0;
        end else if (!bus.start) begin
            // Idle: sign and bit_out keep their last value.
            div_cnt           <= '0;
            sample_en         <= 1'b0;
            phase             <= '0;
            sync_sr           <= '0;
            bit_cnt           <= '0;
            state             <= HUNT;
            bus.bit_valid     <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.sync_found    <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.locked        <= 1'b0;
        end else begin
            sample_en <= (div_cnt == DIV_LAST);
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

            bus.bit_valid     <= 1'b0;
            bus.payload_valid <= 1'b0;
            bus.sync_found    <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.locked        <= (state == PAYLOAD);

            if (sample_en) begin
                sign  <= new_sign;
                phase <= phase_nxt;
                if (phase == HALF) begin
                    bus.bit_out   <= new_sign;
                    bus.bit_valid <= 1'b1;
                    case (state)
                        HUNT: begin
                            sync_sr <= sr_upd;
                            if (match) begin
                                bus.sync_found <= 1'b1;
                                bit_cnt        <= '0;
                                state          <= PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            bus.payload_valid <= 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                bus.frame_done <= 1'b1;
                                bit_cnt        <= '0;
                                sync_sr        <= '0;
                                state          <= HUNT;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_gmsk_bit_sync.sv
// Directed/randomised bench for gmsk_bit_sync against a per-sample reference model.
module tb_gmsk_bit_sync;
    localparam int DW   = 7;
    localparam int SPB  = 8;
    localparam int HYST = 2;
    localparam int FB   = 32;
    localparam int DIV  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gmsk_bit_sync_if #(.DATA_WIDTH(DW)) bus ();

    gmsk_bit_sync #(
        .DATA_WIDTH(DW), .SYS_CLK_FREQ(8000), .SAMPLE_RATE(800),
        .SAMPLES_PER_BIT(SPB), .HYST(HYST), .SYNC_LEN(8),
        .SYNC_WORD(8'hB4), .FRAME_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_sign, m_phase, m_bit, m_hunt, m_hist, m_cnt;

    // observed event tallies
    int          n_bv, n_one, n_pv, n_sf, n_fd;
    logic [31:0] pw;
    logic        dq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input int x);
        int c = 0;
        for (int i = 0; i < 32; i++) c += (x >> i) & 1;
        return c;
    endfunction

    function automatic bit sync_hit(input int h);
`ifdef GMSK_SYNC_TOL_EN
        return popc(h ^ 32'hB4) <= 1;
`else
        return h == 32'hB4;
`endif
    endfunction

    task automatic model_reset();
        m_sign = 0; m_phase = 0; m_bit = 0; m_hunt = 1; m_hist = 0; m_cnt = 0;
    endtask

    task automatic model_abort();
        m_phase = 0; m_hunt = 1; m_hist = 0; m_cnt = 0;
    endtask

    // e = {bit_valid, payload_valid, sync_found, frame_done, bit_out}
    task automatic model_step(input int v, output logic [4:0] e);
        int nsign = m_sign;
        if (v > HYST)       nsign = 1;
        else if (v < -HYST) nsign = 0;
        e = '0;
        if (m_phase == SPB / 2) begin
            m_bit = nsign;
            e[4]  = 1'b1;
            if (m_hunt != 0) begin
                m_hist = ((m_hist << 1) | nsign) & 8'hFF;
                if (sync_hit(m_hist)) begin
                    e[2] = 1'b1; m_hunt = 0; m_cnt = 0;
                end
            end else begin
                e[3] = 1'b1;
                m_cnt++;
                if (m_cnt == FB) begin
                    e[1] = 1'b1; m_hunt = 1; m_hist = 0;
                end
            end
        end
        if (nsign != m_sign && m_phase >= 1 && m_phase < SPB / 2) m_phase = m_phase;
        else if (nsign != m_sign && m_phase > SPB / 2)          m_phase = (m_phase + 2) % SPB;
        else                                                    m_phase = (m_phase + 1) % SPB;
        m_sign = nsign;
        e[0]   = m_bit[0];
    endtask

    function automatic logic [5:0] outs();
        return {bus.bit_valid, bus.payload_valid, bus.sync_found,
                bus.frame_done, bus.bit_out, bus.locked};
    endfunction

    // One sample period; the DUT consumes the sample on the last edge of the loop.
    task automatic send(input int v);
        logic [4:0] e;
        logic       exp_lk, spur, lkbad;
        exp_lk        = (m_hunt == 0);
        bus.sample_in = v[DW-1:0];
        model_step(v, e);
        spur  = 1'b0;
        lkbad = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            @(posedge clk); #1;
            if (i < DIV - 1)
                spur |= bus.bit_valid | bus.payload_valid | bus.sync_found | bus.frame_done;
            if (bus.locked !== exp_lk) lkbad = 1'b1;
        end
        check("quiet_locked", {spur, lkbad}, 2'b00);
        check("pulses", {bus.bit_valid, bus.payload_valid, bus.sync_found,
                         bus.frame_done, bus.bit_out}, e);
        if (bus.bit_valid)     begin n_bv++; n_one += bus.bit_out; dq.push_back(bus.bit_out); end
        if (bus.payload_valid) begin n_pv++; pw = {pw[30:0], bus.bit_out}; end
        if (bus.sync_found)    n_sf++;
        if (bus.frame_done)    n_fd++;
    endtask

    task automatic send_bit(input logic b);
        for (int s = 0; s < SPB; s++) begin
            int amp = 10 + int'($urandom_range(0, 20));
            send(b ? amp : -amp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sf0, pv0, fd0, bv0, one0, cnt;
        logic [31:0] rw;
        logic        stray;
        n_bv = 0; n_one = 0; n_pv = 0; n_sf = 0; n_fd = 0; pw = '0;

        // 1. reset
        bus.start     = 1'b1;
        bus.sample_in = 7'sd20;
        rst           = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outs", outs(), 6'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_outs", outs(), 6'b0);
        model_reset();

        // 2. constant level: decisions every SPB samples, all ones
        for (int i = 0; i < 32; i++) send(20);
        check("const_bit_count", n_bv, 4);
        check("const_ones", n_one, 4);
        check("const_no_sync", n_sf, 0);

        // 3. hysteresis: small samples never flip the sign
        send(20);
        bv0 = n_bv; one0 = n_one;
        for (int i = 0; i < 16; i++) begin
            int sm = int'($urandom_range(1, 2));
            send(($urandom_range(0, 1) != 0) ? sm : -sm);
        end
        check("hyst_decided", (n_bv - bv0) > 0, 1);
        check("hyst_ones", n_one - one0, n_bv - bv0);
        bv0 = n_bv;
        for (int i = 0; i < 8; i++) send(-3);
        check("hyst_flip_decided", n_bv - bv0, 1);
        check("hyst_flip_bit", dq[$], 1'b0);

        // 4. timing loop: first crossing at phase 3, alternating preamble
        cnt = 0;
        while (m_phase != 3 && cnt < 16) begin send(-20); cnt++; end
        check("align_phase3", m_phase, 3);
        for (int i = 0; i < 16; i++) send_bit(((i & 1) == 0));
        for (int j = 0; j < 4; j++)
            check("align_alternate", dq[dq.size()-1-j] ^ dq[dq.size()-2-j], 1'b1);

        // 5. sync + frame, then a second frame
        sf0 = n_sf; pv0 = n_pv; fd0 = n_fd;
        send_word(32'hB4, 8);
        check("frame_sync_once", n_sf - sf0, 1);
        send_word(32'hDEADBEEF, 32);
        check("frame_payload_count", n_pv - pv0, 32);
        check("frame_payload_bits", pw, 32'hDEADBEEF);
        check("frame_done_once", n_fd - fd0, 1);
        rw  = $urandom;
        sf0 = n_sf; pv0 = n_pv;
        send_word(32'hB4, 8);
        send_word(rw, 32);
        check("resync_once", n_sf - sf0, 1);
        check("resync_payload", pw, rw);
        check("resync_count", n_pv - pv0, 32);

        // 6. abort mid-frame
        fd0 = n_fd;
        send_word(32'hB4, 8);
        send_word($urandom, 10);
        check("abort_locked_before", bus.locked, 1'b1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        model_abort();
        check("abort_locked_after", bus.locked, 1'b0);
        stray = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            stray |= bus.bit_valid | bus.payload_valid | bus.sync_found |
                     bus.frame_done | bus.locked | (bus.bit_out !== m_bit[0]);
        end
        check("abort_quiet", stray, 1'b0);
        check("abort_no_frame_done", n_fd - fd0, 0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("restart_edge", outs() & 6'b111101, 6'b0);

        pv0 = n_pv;
        for (int i = 0; i < 16; i++) send_bit(((i & 1) == 0));
        check("restart_no_payload", n_pv - pv0, 0);
        sf0 = n_sf;
        send_word(32'hB5, 8);
`ifdef GMSK_SYNC_TOL_EN
        check("tol_sync_b5", n_sf - sf0, 1);
`else
        check("exact_no_sync_b5", n_sf - sf0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
